// File: rtl/game_flow_controller_pkg.sv
// Shared state encodings and default frame counts for the Frogger game sequencer.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARM         = 3'd1,
        ST_RUNNING     = 3'd2,
        ST_HIT         = 3'd3,
        ST_LEVEL_PAUSE = 3'd4,
        ST_GAME_OVER   = 3'd5
    } state_e;

    localparam int HIT_FRAMES   = 60;
    localparam int LEVEL_FRAMES = 30;
    localparam int OVER_FRAMES  = 120;

    function automatic logic is_timed(input state_e s);
        return (s == ST_HIT) || (s == ST_LEVEL_PAUSE) || (s == ST_GAME_OVER);
    endfunction

endpackage

// File: rtl/game_flow_controller_frame_timer.sv
// Frame counter shared by the timed game phases; done fires on the tick that completes the period.
module game_flow_controller_frame_timer (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Clear,
    input  logic       i_Tick,
    input  logic [7:0] i_Limit,
    output logic [7:0] o_Count,
    output logic       o_Done
);

    logic [7:0] count_q, count_d;

    assign o_Done = i_Tick && (count_q == (i_Limit - 8'd1));

    always_comb begin
        count_d = count_q;
        if (i_Clear)
            count_d = 8'd0;
        else if (i_Tick)
            count_d = count_q + 8'd1;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)
            count_q <= 8'd0;
        else
            count_q <= count_d;
    end

    assign o_Count = count_q;

endmodule

// File: rtl/game_flow_controller.sv
// Frogger game sequencer: phase FSM, lives/level counters and timed freeze periods.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter logic [3:0] C_LIVES_INIT   = 4'b1111,
    parameter int         C_HIT_FRAMES   = HIT_FRAMES,
    parameter int         C_LEVEL_FRAMES = LEVEL_FRAMES,
    parameter int         C_OVER_FRAMES  = OVER_FRAMES,
    parameter int         C_MAX_LEVEL    = 15,
    parameter int         C_BLINK_SHIFT  = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Any_Switch,
    input  logic       i_Has_Collided,
    input  logic       i_Level_Up,
    output logic       o_Game_Active,
    output logic       o_Freeze,
    output logic       o_Respawn,
    output logic       o_Blink,
    output logic [3:0] o_Lives,
    output logic [3:0] o_Level,
    output logic [2:0] o_State
);

    localparam logic [7:0] HIT_LIM   = 8'(C_HIT_FRAMES);
    localparam logic [7:0] LEVEL_LIM = 8'(C_LEVEL_FRAMES);
    localparam logic [7:0] OVER_LIM  = 8'(C_OVER_FRAMES);
    localparam logic [3:0] MAX_LVL   = 4'(C_MAX_LEVEL);

    state_e     state_q, state_d;
    logic [3:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic       respawn_q, respawn_d;
    logic [7:0] limit;
    logic [7:0] count;
    logic       done;
    logic       timed;

    assign timed = is_timed(state_q);

    always_comb begin
        limit = HIT_LIM;
        if (state_q == ST_LEVEL_PAUSE)
            limit = LEVEL_LIM;
        else if (state_q == ST_GAME_OVER)
            limit = OVER_LIM;
    end

    // Timed states are only ever entered from RUNNING, so holding the counter
    // cleared outside them guarantees it starts at zero on entry.
    game_flow_controller_frame_timer u_timer (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Clear (!timed),
        .i_Tick  (i_Frame_Tick),
        .i_Limit (limit),
        .o_Count (count),
        .o_Done  (done)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        respawn_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d = ST_ARM;
                    lives_d = C_LIVES_INIT;
                    level_d = 4'd0;
                end
            end
            ST_ARM: begin
                if (!i_Any_Switch) begin
                    state_d   = ST_RUNNING;
                    respawn_d = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (i_Has_Collided) begin
                    if (lives_q == 4'b0001) begin
                        lives_d = 4'b0000;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q >> 1;
                        state_d = ST_HIT;
                    end
                end else if (i_Level_Up) begin
                    if (level_q != MAX_LVL)
                        level_d = level_q + 4'd1;
                    state_d = ST_LEVEL_PAUSE;
                end
            end
            ST_HIT, ST_LEVEL_PAUSE: begin
                if (done) begin
                    state_d   = ST_RUNNING;
                    respawn_d = 1'b1;
                end
            end
            ST_GAME_OVER: begin
                if (done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            lives_q   <= 4'd0;
            level_q   <= 4'd0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            respawn_q <= respawn_d;
        end
    end

    assign o_Game_Active = (state_q == ST_RUNNING);
    assign o_Freeze      = timed;
    assign o_Respawn     = respawn_q;
    assign o_Blink       = ((state_q == ST_HIT) || (state_q == ST_GAME_OVER)) && count[C_BLINK_SHIFT];
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_State       = state_q;

endmodule
